// File: rtl/id_hazard_pkg.sv
// id_hazard_pkg: shared opcodes, FSM state type and operand-use record for the
// decode-stage hazard scoreboard and the decode stage itself.
package id_hazard_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
  } src_use_t;

endpackage

// File: rtl/id_operand_use.sv
// id_operand_use: decodes an opcode into which register fields the
// instruction reads and writes. Unknown opcodes use no registers at all.
module id_operand_use
  import id_hazard_pkg::*;
(
  input  logic [6:0] opcode,
  output src_use_t   src_use
);

  // Map each opcode class onto its rs1/rs2/rd usage
  always_comb begin
    src_use = '0;
    case (opcode)
      OP_R: begin
        src_use.use_rs1 = 1'b1;
        src_use.use_rs2 = 1'b1;
        src_use.use_rd  = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: begin
        src_use.use_rs1 = 1'b1;
        src_use.use_rd  = 1'b1;
      end
      OP_S: begin
        src_use.use_rs1 = 1'b1;
        src_use.use_rs2 = 1'b1;
      end
      OP_JAL: begin
        src_use.use_rd = 1'b1;
      end
      default: src_use = '0;
    endcase
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: tracks in-flight destination registers between issue
// and writeback, stalls decode on RAW and WAW-capacity hazards, discards the
// decode slot on a jump flush and offers a drain handshake for quiescing.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN lets a consumer issue in the
// same cycle as the writeback that retires its last pending source.
module id_hazard_scoreboard
  import id_hazard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int PEND_W      = 2,
  parameter int STALL_CNT_W = 16,
  localparam int INFL_W     = $clog2(NUM_REGS * (2 ** PEND_W))
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid_i,
  input  logic [31:0]            id_instr_i,
  output logic                   id_ready_o,
  output logic                   stall_o,
  input  logic                   flush_i,
  input  logic                   wb_valid_i,
  input  logic [4:0]             wb_rd_i,
  input  logic                   drain_req_i,
  output logic                   drain_ack_o,
  output logic [INFL_W-1:0]      inflight_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o,
  output logic                   wb_err_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  hz_state_e              state_q, state_d;
  logic [PEND_W-1:0]      cnt_q [NUM_REGS];
  logic [INFL_W-1:0]      inflight_q, inflight_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   wb_err_q, drain_ack_q;

  logic [4:0] rd, rs1, rs2;
  src_use_t   src_use;
  logic       rs1_used, rs2_used, rd_used;
  logic       rs1_busy, rs2_busy, hazard;
  logic       issue, inc_rd, wb_hit, wb_zero, dec_wb;
  logic       unused_instr_bits;

  assign rd  = id_instr_i[11:7];
  assign rs1 = id_instr_i[19:15];
  assign rs2 = id_instr_i[24:20];
  assign unused_instr_bits = ^{id_instr_i[31:25], id_instr_i[14:12]};

  id_operand_use u_operand_use (
    .opcode  (id_instr_i[6:0]),
    .src_use (src_use)
  );

  // x0 is never tracked, so a zero index counts as an unused field
  assign rs1_used = src_use.use_rs1 & (rs1 != 5'd0);
  assign rs2_used = src_use.use_rs2 & (rs2 != 5'd0);
  assign rd_used  = src_use.use_rd  & (rd  != 5'd0);

`ifdef SCOREBOARD_WB_BYPASS_EN
  // A source whose only pending write retires this cycle is forwarded by the register file
  assign rs1_busy = (cnt_q[rs1] != '0) &
                    ~((cnt_q[rs1] == PEND_W'(1)) & wb_valid_i & (wb_rd_i == rs1));
  assign rs2_busy = (cnt_q[rs2] != '0) &
                    ~((cnt_q[rs2] == PEND_W'(1)) & wb_valid_i & (wb_rd_i == rs2));
`else
  assign rs1_busy = (cnt_q[rs1] != '0);
  assign rs2_busy = (cnt_q[rs2] != '0);
`endif

  assign hazard = (rs1_used & rs1_busy) | (rs2_used & rs2_busy) |
                  (rd_used & (cnt_q[rd] == CNT_MAX));

  // Issue gating: drain wins over everything, a flush lets the slot drop without stalling
  always_comb begin
    id_ready_o = 1'b0;
    if (rst_n && (state_q != DRAIN) && !drain_req_i) begin
      id_ready_o = flush_i | ~hazard;
    end
  end

  assign stall_o = rst_n & id_valid_i & ~id_ready_o & ~flush_i;

  assign issue   = id_valid_i & id_ready_o & ~flush_i;
  assign inc_rd  = issue & rd_used;
  assign wb_hit  = wb_valid_i & (wb_rd_i != 5'd0);
  assign wb_zero = wb_hit & (cnt_q[wb_rd_i] == '0);
  assign dec_wb  = wb_hit & ~wb_zero;

  // Next FSM state; RUN and STALL behave alike for issue, STALL just marks a held slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drain_req_i) state_d = DRAIN;
        else if (id_valid_i && hazard && !flush_i) state_d = STALL;
      end
      STALL: begin
        if (drain_req_i) state_d = DRAIN;
        else if (issue || flush_i) state_d = RUN;
      end
      DRAIN: begin
        if (!drain_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Total pending writes moves by one per cycle at most, so it is tracked directly
  always_comb begin
    inflight_d = inflight_q;
    if (inc_rd && !dec_wb) inflight_d = inflight_q + 1'b1;
    else if (dec_wb && !inc_rd) inflight_d = inflight_q - 1'b1;
  end

  // Per-register pending counts; issue and writeback on the same rd cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_rd && (rd == 5'(i)) && !(dec_wb && (wb_rd_i == 5'(i))))
          cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec_wb && (wb_rd_i == 5'(i)) && !(inc_rd && (rd == 5'(i))))
          cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // Control state, in-flight total, stall statistics, sticky error and drain acknowledge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
      wb_err_q    <= 1'b0;
      drain_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (wb_zero) wb_err_q <= 1'b1;
      drain_ack_q <= (state_d == DRAIN) && (inflight_d == '0);
    end
  end

  assign drain_ack_o    = drain_ack_q;
  assign inflight_o     = inflight_q;
  assign stall_cycles_o = stall_cnt_q;
  assign wb_err_o       = wb_err_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: directed scenarios plus a randomized run, each
// checked against a behavioural scoreboard model held in this bench.
module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i;
  logic [31:0] id_instr_i;
  logic        id_ready_o;
  logic        stall_o;
  logic        flush_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        drain_req_i;
  logic        drain_ack_o;
  logic [6:0]  inflight_o;
  logic [15:0] stall_cycles_o;
  logic        wb_err_o;

  int total = 0;
  int bad   = 0;

  int m_cnt [32];
  bit m_drain, m_ack, m_err;
  int m_stall;

  always #5 clk = ~clk;

  id_hazard_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid_i),
    .id_instr_i     (id_instr_i),
    .id_ready_o     (id_ready_o),
    .stall_o        (stall_o),
    .flush_i        (flush_i),
    .wb_valid_i     (wb_valid_i),
    .wb_rd_i        (wb_rd_i),
    .drain_req_i    (drain_req_i),
    .drain_ack_o    (drain_ack_o),
    .inflight_o     (inflight_o),
    .stall_cycles_o (stall_cycles_o),
    .wb_err_o       (wb_err_o)
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'd0, rs2[4:0], rs1[4:0], 3'd0, rd[4:0], op};
  endfunction

  function automatic void uses(input logic [6:0] op, output bit r1, output bit r2, output bit d);
    {r1, r2, d} = 3'b000;
    case (op)
      7'b0110011:                         {r1, r2, d} = 3'b111;
      7'b0010011, 7'b0000011, 7'b1100111: {r1, r2, d} = 3'b101;
      7'b0100011:                         {r1, r2, d} = 3'b110;
      7'b1101111:                         {r1, r2, d} = 3'b001;
      default:                            {r1, r2, d} = 3'b000;
    endcase
  endfunction

  function automatic bit src_busy(input int r);
    if (r == 0 || m_cnt[r] == 0) return 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (m_cnt[r] == 1 && wb_valid_i && int'(wb_rd_i) == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit m_hazard();
    bit r1, r2, d;
    int rd  = int'(id_instr_i[11:7]);
    int rs1 = int'(id_instr_i[19:15]);
    int rs2 = int'(id_instr_i[24:20]);
    uses(id_instr_i[6:0], r1, r2, d);
    return (r1 && src_busy(rs1)) || (r2 && src_busy(rs2)) || (d && rd != 0 && m_cnt[rd] == 3);
  endfunction

  function automatic bit exp_ready();
    if (!rst_n || m_drain || drain_req_i) return 1'b0;
    return flush_i || !m_hazard();
  endfunction

  function automatic bit exp_stall();
    return rst_n && id_valid_i && !exp_ready() && !flush_i;
  endfunction

  function automatic int m_inflight();
    int s = 0;
    for (int r = 0; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  // Drive one cycle's inputs just after the falling edge
  task automatic set_in(input bit v, input logic [31:0] ins, input bit fl,
                        input bit wv, input int wr, input bit dr);
    @(negedge clk);
    id_valid_i  = v;
    id_instr_i  = ins;
    flush_i     = fl;
    wb_valid_i  = wv;
    wb_rd_i     = wr[4:0];
    drain_req_i = dr;
    #1;
  endtask

  // Advance the model by one clock using the inputs currently applied, then cross the edge
  task automatic tick();
    bit r1, r2, d, iss, stl;
    int rd, wb;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_drain = 0; m_ack = 0; m_err = 0; m_stall = 0;
    end else begin
      uses(id_instr_i[6:0], r1, r2, d);
      rd  = int'(id_instr_i[11:7]);
      iss = id_valid_i && exp_ready() && !flush_i;
      stl = exp_stall();
      wb  = wb_valid_i ? int'(wb_rd_i) : 0;
      if (stl && m_stall < 65535) m_stall++;
      if (wb != 0) begin
        if (m_cnt[wb] == 0) m_err = 1;
        else m_cnt[wb]--;
      end
      if (iss && d && rd != 0) m_cnt[rd]++;
      m_drain = drain_req_i;
      m_ack   = m_drain && (m_inflight() == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 32'd0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_in(1, mk(7'b0110011, 1, 2, 3), 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    total++; if (id_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", id_ready_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", stall_o); end
    tick();
    total++; if (inflight_o !== 7'd0) begin bad++; $display("[TB] FAIL reset_inflight: got %0d want 0", inflight_o); end
    total++; if (stall_cycles_o !== 16'd0) begin bad++; $display("[TB] FAIL reset_stallcnt: got %0d want 0", stall_cycles_o); end
    total++; if (wb_err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", wb_err_o); end
    total++; if (drain_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", drain_ack_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_raw_stall();
    int base, issue_at, exp_issue, exp_delta;
    bit rdy;
`ifdef SCOREBOARD_WB_BYPASS_EN
    exp_issue = 4; exp_delta = 3;
`else
    exp_issue = 5; exp_delta = 4;
`endif
    base = m_stall;
    issue_at = -1;
    set_in(1, mk(7'b0110011, 5, 1, 2), 0, 0, 0, 0);
    total++; if (id_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL raw_producer_ready: got %b want 1", id_ready_o); end
    tick();
    for (int c = 1; c <= 10 && issue_at < 0; c++) begin
      set_in(1, mk(7'b0110011, 6, 5, 1), 0, c == 4, 5, 0);
      total++; if (stall_o !== exp_stall()) begin bad++; $display("[TB] FAIL raw_stall_c%0d: got %b want %b", c, stall_o, exp_stall()); end
      rdy = id_ready_o;
      tick();
      if (rdy) issue_at = c;
    end
    set_in(0, 32'd0, 0, 0, 0, 0);
    total++; if (issue_at != exp_issue) begin bad++; $display("[TB] FAIL raw_issue_cycle: got %0d want %0d", issue_at, exp_issue); end
    total++; if (stall_cycles_o !== 16'(base + exp_delta)) begin bad++; $display("[TB] FAIL raw_stallcnt: got %0d want %0d", stall_cycles_o, base + exp_delta); end
    tick();
  endtask

  task automatic test_waw_capacity();
    int exp_inf [6] = '{1, 2, 3, 3, 2, 3};
    bit exp_rdy [6] = '{1, 1, 1, 0, 0, 1};
    for (int c = 0; c < 6; c++) begin
      set_in(1, mk(7'b0000011, 7, 0, 0), 0, c == 4, 7, 0);
      total++; if (id_ready_o !== exp_rdy[c]) begin bad++; $display("[TB] FAIL waw_ready_c%0d: got %b want %b", c, id_ready_o, exp_rdy[c]); end
      tick();
      total++; if (inflight_o !== 7'(exp_inf[c])) begin bad++; $display("[TB] FAIL waw_inflight_c%0d: got %0d want %0d", c, inflight_o, exp_inf[c]); end
    end
    set_in(0, 32'd0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_flush();
    set_in(1, mk(7'b0110011, 5, 1, 2), 0, 0, 0, 0);
    tick();
    set_in(1, mk(7'b0110011, 6, 5, 1), 0, 0, 0, 0);
    total++; if (stall_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre_stall: got %b want 1", stall_o); end
    tick();
    set_in(1, mk(7'b0110011, 6, 5, 1), 1, 0, 0, 0);
    total++; if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_stall: got %b want 0", stall_o); end
    total++; if (id_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready: got %b want 1", id_ready_o); end
    tick();
    set_in(1, mk(7'b0110011, 7, 6, 0), 0, 0, 0, 0);
    total++; if (inflight_o !== 7'd1) begin bad++; $display("[TB] FAIL flush_inflight: got %0d want 1", inflight_o); end
    total++; if (id_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_x6_free: got %b want 1", id_ready_o); end
    tick();
  endtask

  task automatic test_drain();
    set_in(1, mk(7'b0000011, 8, 0, 0), 0, 0, 0, 0);
    tick();
    set_in(1, mk(7'b0000011, 9, 0, 0), 0, 0, 0, 0);
    tick();
    for (int c = 0; c <= 6; c++) begin
      set_in(1, mk(7'b0110011, 10, 0, 0), 0, c == 3 || c == 5, (c == 3) ? 8 : 9, 1);
      total++; if (id_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_ready_c%0d: got %b want 0", c, id_ready_o); end
      total++; if (drain_ack_o !== (c == 6)) begin bad++; $display("[TB] FAIL drain_ack_c%0d: got %b want %b", c, drain_ack_o, c == 6); end
      tick();
    end
    set_in(0, 32'd0, 0, 0, 0, 0);
    total++; if (drain_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL drain_ack_hold: got %b want 1", drain_ack_o); end
    tick();
    set_in(1, mk(7'b0110011, 10, 0, 0), 0, 0, 0, 0);
    total++; if (drain_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_ack_drop: got %b want 0", drain_ack_o); end
    total++; if (id_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL drain_exit_ready: got %b want 1", id_ready_o); end
    tick();
  endtask

  task automatic test_wb_err();
    set_in(0, 32'd0, 0, 1, 0, 0);
    tick();
    total++; if (wb_err_o !== 1'b0) begin bad++; $display("[TB] FAIL err_x0: got %b want 0", wb_err_o); end
    set_in(0, 32'd0, 0, 1, 9, 0);
    tick();
    total++; if (wb_err_o !== 1'b1) begin bad++; $display("[TB] FAIL err_set: got %b want 1", wb_err_o); end
    for (int c = 0; c < 3; c++) begin
      set_in(1, mk(7'b0010011, 4, 0, 0), 0, 0, 0, 0);
      tick();
      total++; if (wb_err_o !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky_c%0d: got %b want 1", c, wb_err_o); end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 1; i <= 3; i++) begin
      set_in(1, mk(7'b0000011, i, 0, 0), 0, 0, 0, 0);
      tick();
    end
    set_in(1, mk(7'b0110011, 1, 2, 3), 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    total++; if (id_ready_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_comb: got ready=%b stall=%b want 0/0", id_ready_o, stall_o); end
    tick();
    total++; if (inflight_o !== 7'd0) begin bad++; $display("[TB] FAIL midrst_inflight: got %0d want 0", inflight_o); end
    total++; if (wb_err_o !== 1'b0 || drain_ack_o !== 1'b0 || stall_cycles_o !== 16'd0) begin
      bad++; $display("[TB] FAIL midrst_regs: got err=%b ack=%b stallcnt=%0d want 0/0/0", wb_err_o, drain_ack_o, stall_cycles_o);
    end
    rst_n = 1'b1;
    #1;
    total++; if (id_ready_o !== 1'b1 || stall_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_issue: got ready=%b stall=%b want 1/0", id_ready_o, stall_o); end
    tick();
    set_in(0, 32'd0, 0, 1, 2, 0);
    tick();
    total++; if (wb_err_o !== 1'b1) begin bad++; $display("[TB] FAIL midrst_stale_wb: got %b want 1", wb_err_o); end
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    int q[$];
    bit v, fl, wv, dr;
    int wr;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1101111, 7'b1110011, 7'b0110111};
    dr = 0;
    for (int n = 0; n < 400; n++) begin
      q.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) q.push_back(r);
      v  = ($urandom_range(0, 99) < 80);
      fl = ($urandom_range(0, 99) < 8);
      wv = 0; wr = 0;
      if (q.size() > 0 && $urandom_range(0, 99) < 45) begin
        wv = 1; wr = q[$urandom_range(0, q.size() - 1)];
      end else if ($urandom_range(0, 99) < 4) begin
        wv = 1; wr = $urandom_range(0, 31);
      end
      if ($urandom_range(0, 99) < 6) dr = ~dr;
      rst_n = ($urandom_range(0, 199) != 0);
      set_in(v, mk(ops[$urandom_range(0, 7)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)), fl, wv, wr, dr);
      total++; if (id_ready_o !== exp_ready()) begin bad++; $display("[TB] FAIL rnd_ready_%0d: got %b want %b", n, id_ready_o, exp_ready()); end
      total++; if (stall_o !== exp_stall()) begin bad++; $display("[TB] FAIL rnd_stall_%0d: got %b want %b", n, stall_o, exp_stall()); end
      tick();
      total++; if (inflight_o !== 7'(m_inflight())) begin bad++; $display("[TB] FAIL rnd_inflight_%0d: got %0d want %0d", n, inflight_o, m_inflight()); end
      total++; if (stall_cycles_o !== 16'(m_stall)) begin bad++; $display("[TB] FAIL rnd_stallcnt_%0d: got %0d want %0d", n, stall_cycles_o, m_stall); end
      total++; if (drain_ack_o !== m_ack) begin bad++; $display("[TB] FAIL rnd_ack_%0d: got %b want %b", n, drain_ack_o, m_ack); end
      total++; if (wb_err_o !== m_err) begin bad++; $display("[TB] FAIL rnd_err_%0d: got %b want %b", n, wb_err_o, m_err); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    id_valid_i  = 1'b0;
    id_instr_i  = 32'd0;
    flush_i     = 1'b0;
    wb_valid_i  = 1'b0;
    wb_rd_i     = 5'd0;
    drain_req_i = 1'b0;
    test_reset();
    test_raw_stall();
    do_reset();
    test_waw_capacity();
    do_reset();
    test_flush();
    do_reset();
    test_drain();
    do_reset();
    test_wb_err();
    test_reset_midflight();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
